// File: rtl/wb_dp_sram_arb_if.sv
// Bus bundle for the dual-port Wishbone-to-SRAM arbiter: two classic Wishbone
// slave ports plus the single-port SRAM drive/return signals.
interface wb_dp_sram_arb_if #(
    parameter int dw     = 32,
    parameter int aw     = 32,
    parameter int col_w  = 8,
    parameter int mem_aw = 8
);
    localparam int nb_w = dw / col_w;

    logic              wb0_cyc_i;
    logic              wb0_stb_i;
    logic              wb0_we_i;
    logic [aw-1:0]     wb0_adr_i;
    logic [nb_w-1:0]   wb0_sel_i;
    logic [dw-1:0]     wb0_dat_i;
    logic [dw-1:0]     wb0_dat_o;
    logic              wb0_ack_o;

    logic              wb1_cyc_i;
    logic              wb1_stb_i;
    logic              wb1_we_i;
    logic [aw-1:0]     wb1_adr_i;
    logic [nb_w-1:0]   wb1_sel_i;
    logic [dw-1:0]     wb1_dat_i;
    logic [dw-1:0]     wb1_dat_o;
    logic              wb1_ack_o;

    logic              mem_ce_o;
    logic [mem_aw-1:0] mem_adr_o;
    logic [nb_w-1:0]   mem_we_o;
    logic [dw-1:0]     mem_dat_o;
    logic [dw-1:0]     mem_dat_i;

    modport slave (
        input  wb0_cyc_i, wb0_stb_i, wb0_we_i, wb0_adr_i, wb0_sel_i, wb0_dat_i,
        output wb0_dat_o, wb0_ack_o,
        input  wb1_cyc_i, wb1_stb_i, wb1_we_i, wb1_adr_i, wb1_sel_i, wb1_dat_i,
        output wb1_dat_o, wb1_ack_o,
        output mem_ce_o, mem_adr_o, mem_we_o, mem_dat_o,
        input  mem_dat_i
    );

    modport master (
        output wb0_cyc_i, wb0_stb_i, wb0_we_i, wb0_adr_i, wb0_sel_i, wb0_dat_i,
        input  wb0_dat_o, wb0_ack_o,
        output wb1_cyc_i, wb1_stb_i, wb1_we_i, wb1_adr_i, wb1_sel_i, wb1_dat_i,
        input  wb1_dat_o, wb1_ack_o,
        input  mem_ce_o, mem_adr_o, mem_we_o, mem_dat_o,
        output mem_dat_i
    );
endinterface

// File: rtl/wb_dp_sram_arb.sv
// Two Wishbone classic slave ports sharing one synchronous single-port SRAM.
// Round-robin arbitration, one transfer every three cycles (IDLE/ACCESS/ACK).
module wb_dp_sram_arb #(
    parameter int dw     = 32,
    parameter int aw     = 32,
    parameter int col_w  = 8,
    parameter int mem_aw = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    wb_dp_sram_arb_if.slave         bus
);
    localparam int nb_w = dw / col_w;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t            state;
    logic              grant_p1;
    logic              last_srv;
    logic              write_p1;
    logic              mem_ce_p1;
    logic [mem_aw-1:0] mem_adr_p1;
    logic [nb_w-1:0]   mem_we_p1;
    logic [dw-1:0]     mem_dat_p1;

    logic              req0;
    logic              req1;
    logic              pick;
    logic              pick_we;
    logic [aw-1:0]     pick_adr;
    logic [nb_w-1:0]   pick_sel;
    logic [dw-1:0]     pick_dat;
    logic              ack0;
    logic              ack1;
    logic              unused_adr_bits;

    function automatic logic [mem_aw-1:0] word_addr(input logic [aw-1:0] byte_adr);
        return byte_adr[mem_aw+1:2];
    endfunction

    function automatic logic [nb_w-1:0] lane_we(input logic we, input logic [nb_w-1:0] sel);
        return we ? sel : '0;
    endfunction

    assign req0 = bus.wb0_cyc_i & bus.wb0_stb_i;
    assign req1 = bus.wb1_cyc_i & bus.wb1_stb_i;

    // A tie goes to whichever port was not served last; a lone requester always wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_srv;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        pick_we  = bus.wb0_we_i;
        pick_adr = bus.wb0_adr_i;
        pick_sel = bus.wb0_sel_i;
        pick_dat = bus.wb0_dat_i;
        if (pick) begin
            pick_we  = bus.wb1_we_i;
            pick_adr = bus.wb1_adr_i;
            pick_sel = bus.wb1_sel_i;
            pick_dat = bus.wb1_dat_i;
        end
    end

    // Only the word-index field of each address reaches the SRAM.
    assign unused_adr_bits = ^{bus.wb0_adr_i, bus.wb1_adr_i};

    // IDLE -> ACCESS: grant and SRAM command captured together
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            grant_p1   <= 1'b0;
            last_srv   <= 1'b1;
            write_p1   <= 1'b0;
            mem_ce_p1  <= 1'b0;
            mem_adr_p1 <= '0;
            mem_we_p1  <= '0;
            mem_dat_p1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state      <= ACCESS;
                        grant_p1   <= pick;
                        last_srv   <= pick;
                        write_p1   <= pick_we;
                        mem_ce_p1  <= 1'b1;
                        mem_adr_p1 <= word_addr(pick_adr);
                        mem_we_p1  <= lane_we(pick_we, pick_sel);
                        mem_dat_p1 <= pick_dat;
                    end
                end
                ACCESS: begin
                    state     <= ACK;
                    mem_ce_p1 <= 1'b0;
                    mem_we_p1 <= '0;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_ce_p1 <= 1'b0;
                    mem_we_p1 <= '0;
                end
            endcase
        end
    end

    // ACK stage: ack follows the live cyc&stb so a requester that aborts in ACK sees none.
    assign ack0 = (state == ACK) && !grant_p1 && req0;
    assign ack1 = (state == ACK) &&  grant_p1 && req1;

    assign bus.wb0_ack_o = ack0;
    assign bus.wb1_ack_o = ack1;
    assign bus.wb0_dat_o = (ack0 && !write_p1) ? bus.mem_dat_i : '0;
    assign bus.wb1_dat_o = (ack1 && !write_p1) ? bus.mem_dat_i : '0;

    assign bus.mem_ce_o  = mem_ce_p1;
    assign bus.mem_adr_o = mem_adr_p1;
    assign bus.mem_we_o  = mem_we_p1;
    assign bus.mem_dat_o = mem_dat_p1;

    a_single_ack: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(ack0 && ack1));
    a_ce_in_access: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        mem_ce_p1 |-> (state == ACCESS));
    a_we_needs_ce: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (mem_we_p1 != '0) |-> mem_ce_p1);
endmodule

// File: tb/tb_wb_dp_sram_arb.sv
// Bench for wb_dp_sram_arb: SRAM model, transaction-level reference checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_dp_sram_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] rd_q;

    always #5 clk = ~clk;

    wb_dp_sram_arb_if #(.dw(32), .aw(32), .col_w(8), .mem_aw(8)) bus ();

    wb_dp_sram_arb #(.dw(32), .aw(32), .col_w(8), .mem_aw(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    assign bus.mem_dat_i = rd_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // Synchronous SRAM: read data appears the cycle after ce is sampled.
    initial begin : sram_model
        logic [31:0] sram [256];
        for (int i = 0; i < 256; i++) sram[i] = {i[7:0], 24'h667788};
        rd_q = '0;
        forever begin
            @(posedge clk);
            if (bus.mem_ce_o) begin
                rd_q <= sram[bus.mem_adr_o];
                for (int b = 0; b < 4; b++)
                    if (bus.mem_we_o[b]) sram[bus.mem_adr_o][8*b +: 8] = bus.mem_dat_o[8*b +: 8];
            end
        end
    end

    // Reference: a transfer accepted when free occupies the SRAM on the next
    // cycle and completes on the one after that.
    initial begin : ref_model
        logic [31:0] ref_mem [256];
        int          slot;
        int          last;
        int          tp;
        logic        twe;
        logic [3:0]  tsel;
        logic [7:0]  tw;
        logic [31:0] tdat;
        logic        r0, r1, e0, e1;
        logic [31:0] d0, d1;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) ref_mem[i] = {i[7:0], 24'h667788};
        slot = 0; last = 1; tp = 0; twe = 0; tsel = 0; tw = 0; tdat = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                slot = 0;
                last = 1;
                check("rst_ctl", {28'd0, bus.wb0_ack_o, bus.wb1_ack_o, bus.mem_ce_o, |bus.mem_we_o}, 32'd0);
                check("rst_adr", {24'd0, bus.mem_adr_o}, 32'd0);
                check("rst_mdat", bus.mem_dat_o, 32'd0);
                check("rst_dat", bus.wb0_dat_o | bus.wb1_dat_o, 32'd0);
            end else begin
                r0 = bus.wb0_cyc_i && bus.wb0_stb_i;
                r1 = bus.wb1_cyc_i && bus.wb1_stb_i;
                e0 = (slot == 2) && (tp == 0) && r0;
                e1 = (slot == 2) && (tp == 1) && r1;
                d0 = (e0 && !twe) ? ref_mem[tw] : 32'd0;
                d1 = (e1 && !twe) ? ref_mem[tw] : 32'd0;
                check("ack0", 32'(bus.wb0_ack_o), 32'(e0));
                check("ack1", 32'(bus.wb1_ack_o), 32'(e1));
                check("dat0", bus.wb0_dat_o, d0);
                check("dat1", bus.wb1_dat_o, d1);
                check("mem_ce", 32'(bus.mem_ce_o), 32'(slot == 1));
                check("mem_we", 32'(bus.mem_we_o), (slot == 1 && twe) ? 32'(tsel) : 32'd0);
                if (slot == 1) begin
                    check("mem_adr", 32'(bus.mem_adr_o), 32'(tw));
                    check("mem_dat", bus.mem_dat_o, tdat);
                end
                if (slot == 0) begin
                    if (r0 || r1) begin
                        tp   = (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
                        last = tp;
                        a    = (tp == 0) ? bus.wb0_adr_i : bus.wb1_adr_i;
                        tw   = 8'((a / 4) % 256);
                        twe  = (tp == 0) ? bus.wb0_we_i : bus.wb1_we_i;
                        tsel = (tp == 0) ? bus.wb0_sel_i : bus.wb1_sel_i;
                        tdat = (tp == 0) ? bus.wb0_dat_i : bus.wb1_dat_i;
                        slot = 1;
                    end
                end else if (slot == 1) begin
                    if (twe)
                        for (int b = 0; b < 4; b++)
                            if (tsel[b]) ref_mem[tw][8*b +: 8] = tdat[8*b +: 8];
                    slot = 2;
                end else begin
                    slot = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [3:0] sl, input logic [31:0] d);
        if (p == 0) begin
            bus.wb0_cyc_i = c; bus.wb0_stb_i = s; bus.wb0_we_i = w;
            bus.wb0_adr_i = a; bus.wb0_sel_i = sl; bus.wb0_dat_i = d;
        end else begin
            bus.wb1_cyc_i = c; bus.wb1_stb_i = s; bus.wb1_we_i = w;
            bus.wb1_adr_i = a; bus.wb1_sel_i = sl; bus.wb1_dat_i = d;
        end
    endtask

    task automatic idle_port(input int p);
        drive(p, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    // One transfer on port p; lat is the number of cycles from request to ack (-1 if none).
    task automatic xfer(input int p, input logic w, input logic [31:0] a, input logic [3:0] sl,
                        input logic [31:0] d, output logic [31:0] rdata, output int lat,
                        output logic [7:0] acc_adr, output logic [3:0] acc_we);
        drive(p, 1'b1, 1'b1, w, a, sl, d);
        lat = -1; rdata = '0; acc_adr = '0; acc_we = '0;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.mem_ce_o) begin
                acc_adr = bus.mem_adr_o;
                acc_we  = bus.mem_we_o;
            end
            if ((p == 0 && bus.wb0_ack_o) || (p == 1 && bus.wb1_ack_o)) begin
                lat   = k;
                rdata = (p == 0) ? bus.wb0_dat_o : bus.wb1_dat_o;
            end
            tick();
        end
        idle_port(p);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        logic [31:0] rdata;
        int          lat;
        int          first_k;
        int          first_p;
        logic [7:0]  aadr;
        logic [3:0]  awe;
        idle_port(0);
        idle_port(1);
        repeat (3) tick();
        rst_n = 1'b1;

        // Byte-lane write then read-back of the merged word.
        xfer(0, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD, rdata, lat, aadr, awe);
        check("wr_latency", 32'(lat), 32'd2);
        check("wr_adr", 32'(aadr), 32'd4);
        check("wr_we", 32'(awe), 32'h5);
        xfer(0, 1'b0, 32'h10, 4'hF, 32'd0, rdata, lat, aadr, awe);
        check("rb_latency", 32'(lat), 32'd2);
        check("rb_data", rdata, 32'h04BB77DD);

        // Address wrap above the SRAM range.
        xfer(1, 1'b0, 32'h400, 4'hF, 32'd0, rdata, lat, aadr, awe);
        check("wrap_adr", 32'(aadr), 32'd0);
        check("wrap_data", rdata, 32'h00667788);

        // Lone port-1 request right after port 1 was served; low bits ignored.
        xfer(1, 1'b0, 32'h80F, 4'hF, 32'd0, rdata, lat, aadr, awe);
        check("p1_again_latency", 32'(lat), 32'd2);
        check("p1_again_adr", 32'(aadr), 32'd3);
        check("p1_again_data", rdata, 32'h03667788);

        // Write aborted by dropping stb during ACCESS: still committed, no ack.
        drive(0, 1'b1, 1'b1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        tick();
        bus.wb0_stb_i = 1'b0;
        @(negedge clk);
        check("abort_ce", 32'(bus.mem_ce_o), 32'd1);
        check("abort_we", 32'(bus.mem_we_o), 32'hF);
        tick();
        @(negedge clk);
        check("abort_no_ack", 32'(bus.wb0_ack_o), 32'd0);
        tick();
        xfer(0, 1'b0, 32'h20, 4'hF, 32'd0, rdata, lat, aadr, awe);
        check("abort_idle_latency", 32'(lat), 32'd2);
        check("abort_commit_data", rdata, 32'hCAFEF00D);

        // Both ports reading continuously from reset.
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h4, 4'hF, 32'd0);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h8, 4'hF, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("rr_ack0", 32'(bus.wb0_ack_o), 32'(k == 2 || k == 8));
            check("rr_ack1", 32'(bus.wb1_ack_o), 32'(k == 5 || k == 11));
            if (bus.wb0_ack_o) check("rr_dat0", bus.wb0_dat_o, 32'h01667788);
            if (bus.wb1_ack_o) check("rr_dat1", bus.wb1_dat_o, 32'h02667788);
            tick();
        end
        idle_port(0);
        idle_port(1);
        tick();

        // Reset pulsed in ACCESS of a port-0 read; next tie must go to port 0.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'd0);
        @(negedge clk);
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("arst_ce_we", {30'd0, bus.mem_ce_o, |bus.mem_we_o}, 32'd0);
        check("arst_adr", 32'(bus.mem_adr_o), 32'd0);
        check("arst_mdat", bus.mem_dat_o, 32'd0);
        check("arst_ack", {30'd0, bus.wb0_ack_o, bus.wb1_ack_o}, 32'd0);
        idle_port(0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h4, 4'hF, 32'd0);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h8, 4'hF, 32'd0);
        first_k = -1;
        first_p = -1;
        for (int k = 0; k < 6 && first_k < 0; k++) begin
            @(negedge clk);
            if (bus.wb0_ack_o || bus.wb1_ack_o) begin
                first_k = k;
                first_p = bus.wb0_ack_o ? 0 : 1;
            end
            tick();
        end
        check("arst_tie_port", 32'(first_p), 32'd0);
        check("arst_tie_cycle", 32'(first_k), 32'd2);
        idle_port(0);
        idle_port(1);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_dp_sram_arb.md
WB_DP_SRAM_ARB -- requirements
Module: wb_dp_sram_arb

Interface
REQ-001 Parameter dw, default 32: data width of both Wishbone ports and the SRAM.
REQ-002 Parameter aw, default 32: Wishbone byte-address width.
REQ-003 Parameter col_w, default 8: byte-lane width; nb_w = dw/col_w select/write-enable lanes.
REQ-004 Parameter mem_aw, default 8: SRAM word-address width.
REQ-005 clk_i  in  1  single clock; all logic rising-edge.
REQ-006 rst_n_i  in  1  asynchronous, active-low reset.
REQ-007 wbN_cyc_i, wbN_stb_i, wbN_we_i  in  1 each  Wishbone classic slave controls, N = 0,1.
REQ-008 wbN_adr_i  in  aw  byte address; wbN_sel_i  in  nb_w  lane selects; wbN_dat_i  in  dw  write data.
REQ-009 wbN_dat_o  out  dw  read data; wbN_ack_o  out  1  transfer acknowledge.
REQ-010 mem_ce_o  out  1; mem_adr_o  out  mem_aw; mem_we_o  out  nb_w; mem_dat_o  out  dw  SRAM drive.
REQ-011 mem_dat_i  in  dw  SRAM read data, valid one cycle after the cycle mem_ce_o is sampled high.

Function
REQ-012 Port N requests when wbN_cyc_i & wbN_stb_i.
REQ-013 FSM states IDLE, ACCESS, ACK; IDLE->ACCESS when any request present; ACCESS->ACK always; ACK->IDLE always.
REQ-014 In IDLE with one request, that port is granted; with both, the port not served last is granted (round-robin).
REQ-015 Grant and last-served pointer are registered on the IDLE->ACCESS edge; last-served resets to port 1 so port 0 wins the first tie.
REQ-016 mem_* outputs are registered, loaded on IDLE->ACCESS and valid only during ACCESS: mem_ce_o=1, mem_adr_o=wbN_adr_i[mem_aw+1:2], mem_dat_o=wbN_dat_i.
REQ-017 mem_we_o = wbN_sel_i when wbN_we_i=1, else all zero; outside ACCESS mem_ce_o=0 and mem_we_o=0.
REQ-018 In ACK, wbN_ack_o=1 for the granted port only, and only if its cyc&stb is still high; the other port's ack stays 0.
REQ-019 wbN_dat_o = mem_dat_i while wbN_ack_o=1 on a read, otherwise all zero.
REQ-020 Latency: request seen in IDLE at cycle T -> SRAM access at T+1 -> ack at T+2; back-to-back throughput one transfer per 3 cycles.
REQ-021 Requester abort (cyc or stb low in ACCESS/ACK): a write issued in ACCESS is still committed; no ack is given; FSM returns to IDLE normally.
REQ-022 Address bits above mem_aw+1 are ignored (aliasing wrap); bits [1:0] are ignored.
REQ-023 The arbiter never grants both ports in one transfer and never issues mem_ce_o for a non-granted port.
REQ-024 Request changes on the losing port during ACCESS/ACK do not affect the in-flight transfer.

Reset
REQ-025 rst_n_i low asynchronously forces IDLE, both acks 0, both dat_o 0, mem_ce_o 0, mem_we_o 0, mem_adr_o 0, mem_dat_o 0, last-served = port 1.
REQ-026 Reset asserted mid-transfer aborts it without ack; a write already sampled by the SRAM is not undone.
REQ-027 After rst_n_i deasserts, the first IDLE cycle may accept a request.

Verification
REQ-028 Port 0 write adr 0x10, sel 4'b0101, data 0xAABBCCDD -> at T+1 mem_adr_o=4, mem_we_o=4'b0101; wb0_ack_o at T+2; read back gives 0x??BB??DD with untouched lanes preserved.
REQ-029 Both ports request reads continuously from reset -> grants alternate 0,1,0,1; each ack 3 cycles apart; port 1 ack never coincides with port 0 ack.
REQ-030 Port 1 read adr 0x400 with mem_aw=8 -> mem_adr_o=0 (wrap), data equals word at adr 0x000.
REQ-031 Port 0 drops stb in ACCESS of a write -> SRAM write occurs, wb0_ack_o stays 0, FSM back in IDLE at T+3.
REQ-032 rst_n_i pulsed low during ACCESS -> all outputs zero immediately (asynchronous), no ack, next tie goes to port 0.
REQ-033 Single port 1 request while idle -> granted at once despite last-served=port 1.
